// File: rtl/mips_core.sv
// Shared core package: arbitration modes and AXI read-channel widths.
package mips_core;

  typedef enum logic [0:0] {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_t;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned LEN_WIDTH  = 8;
  localparam int unsigned RESP_WIDTH = 2;
  localparam int unsigned CNT_WIDTH  = 4;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_address.sv
// AXI read-address (AR) channel bundle; master drives the request, slave returns ready.
interface axi_read_address;

  logic                             valid;
  logic                             ready;
  logic [mips_core::ID_WIDTH-1:0]   id;
  logic [mips_core::LEN_WIDTH-1:0]  len;
  logic [mips_core::ADDR_WIDTH-1:0] addr;

  modport master (output valid, id, len, addr, input ready);
  modport slave  (input valid, id, len, addr, output ready);

endinterface

// File: rtl/axi_read_data.sv
// AXI read-data (R) channel bundle; the master side consumes beats and returns ready.
interface axi_read_data;

  logic                             valid;
  logic                             ready;
  logic [mips_core::ID_WIDTH-1:0]   id;
  logic [mips_core::DATA_WIDTH-1:0] data;
  logic [mips_core::RESP_WIDTH-1:0] resp;
  logic                             last;

  modport master (input valid, id, data, resp, last, output ready);
  modport slave  (output valid, id, data, resp, last, input ready);

endinterface

// File: rtl/rr_grant_picker.sv
// Picks the first asserted request searching upward from base_i, wrapping modulo N.
module rr_grant_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] base_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  always_comb begin
    int unsigned idx;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(base_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!gnt_vld_o && req_i[idx[IdxW-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-to-1 AXI read arbiter: registered AR mux with per-master burst credit,
// registered R demux routed by RID.
module axi_read_arbiter
  import mips_core::*;
#(
  parameter int unsigned READ_MASTERS    = 2,
  parameter arb_mode_t   ARB_MODE        = ARB_FIXED,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  axi_read_address.slave                         mem_read_address [READ_MASTERS],
  axi_read_data.slave                            mem_read_data    [READ_MASTERS],
  axi_read_address.master                        axi_read_address,
  axi_read_data.master                           axi_read_data,
  output logic [READ_MASTERS-1:0][CNT_WIDTH-1:0] outstanding,
  output logic                                   err_bad_id
);

  localparam int unsigned          IdxW    = idx_width(READ_MASTERS);
  localparam logic [CNT_WIDTH-1:0] MaxCnt  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(READ_MASTERS - 1);

  // Flattened per-master view of the interface arrays.
  logic [READ_MASTERS-1:0] m_arvalid;
  logic [READ_MASTERS-1:0] m_arready;
  logic [READ_MASTERS-1:0] m_rready;
  logic [ID_WIDTH-1:0]     m_arid   [READ_MASTERS];
  logic [LEN_WIDTH-1:0]    m_arlen  [READ_MASTERS];
  logic [ADDR_WIDTH-1:0]   m_araddr [READ_MASTERS];

  // AR stage
  logic                  ar_valid_q, ar_valid_d;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [LEN_WIDTH-1:0]  ar_len_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [IdxW-1:0]       base;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_vld;
  logic                  stage_ready;
  logic                  ar_accept;
  logic [READ_MASTERS-1:0] req;

  // R stage
  logic                  pipe_valid_q, pipe_valid_d;
  logic [ID_WIDTH-1:0]   pipe_id_q;
  logic [DATA_WIDTH-1:0] pipe_data_q;
  logic [RESP_WIDTH-1:0] pipe_resp_q;
  logic                  pipe_last_q;
  logic [IdxW-1:0]       pipe_sel;
  logic                  pipe_take;
  logic                  r_ready_ext;
  logic                  r_accept;
  logic                  r_id_ok;

  // Credit counters and error flag
  logic [READ_MASTERS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [READ_MASTERS-1:0] inc_vec;
  logic [READ_MASTERS-1:0] dec_vec;
  logic                    underflow;
  logic                    err_q, err_d;

  for (genvar g = 0; g < READ_MASTERS; g++) begin : g_port
    assign m_arvalid[g]              = mem_read_address[g].valid;
    assign m_arid[g]                 = mem_read_address[g].id;
    assign m_arlen[g]                = mem_read_address[g].len;
    assign m_araddr[g]               = mem_read_address[g].addr;
    assign mem_read_address[g].ready = m_arready[g];

    assign m_rready[g]            = mem_read_data[g].ready;
    assign mem_read_data[g].valid = pipe_valid_q && (pipe_sel == IdxW'(g));
    assign mem_read_data[g].id    = pipe_id_q;
    assign mem_read_data[g].data  = pipe_data_q;
    assign mem_read_data[g].resp  = pipe_resp_q;
    assign mem_read_data[g].last  = pipe_last_q;
  end

  // ---------------------------------------------------------------------------
  // AR arbitration and register stage
  // ---------------------------------------------------------------------------
  always_comb begin
    req = '0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      req[i] = m_arvalid[i] && (cnt_q[i] < MaxCnt);
    end
  end

  always_comb begin
    base = '0;
    if (ARB_MODE == ARB_ROUND_ROBIN) begin
      base = (last_grant_q == LastIdx) ? '0 : last_grant_q + 1'b1;
    end
  end

  rr_grant_picker #(
    .N    (READ_MASTERS),
    .IdxW (IdxW)
  ) u_picker (
    .req_i     (req),
    .base_i    (base),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign stage_ready = !ar_valid_q || axi_read_address.ready;
  assign ar_accept   = stage_ready && gnt_vld;

  always_comb begin
    m_arready = '0;
    if (ar_accept) begin
      m_arready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ar_valid_d   = ar_valid_q;
    last_grant_d = last_grant_q;
    if (stage_ready) begin
      ar_valid_d = gnt_vld;
    end
    if (ar_accept) begin
      last_grant_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_accept) begin
      ar_id_q   <= m_arid[gnt_idx];
      ar_len_q  <= m_arlen[gnt_idx];
      ar_addr_q <= m_araddr[gnt_idx];
    end
  end

  assign axi_read_address.valid = ar_valid_q;
  assign axi_read_address.id    = ar_id_q;
  assign axi_read_address.len   = ar_len_q;
  assign axi_read_address.addr  = ar_addr_q;

  // ---------------------------------------------------------------------------
  // R register stage and routing
  // ---------------------------------------------------------------------------
  assign pipe_sel    = pipe_id_q[IdxW-1:0];
  assign pipe_take   = pipe_valid_q && m_rready[pipe_sel];
  assign r_ready_ext = !pipe_valid_q || m_rready[pipe_sel];
  assign r_accept    = axi_read_data.valid && r_ready_ext;
  assign r_id_ok     = 32'(axi_read_data.id) < READ_MASTERS;

  assign axi_read_data.ready = r_ready_ext;

  // An unroutable beat is swallowed: it empties the stage rather than filling it.
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    if (r_accept) begin
      pipe_valid_d = r_id_ok;
    end else if (pipe_take) begin
      pipe_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_accept && r_id_ok) begin
      pipe_id_q   <= axi_read_data.id;
      pipe_data_q <= axi_read_data.data;
      pipe_resp_q <= axi_read_data.resp;
      pipe_last_q <= axi_read_data.last;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-burst credit per master
  // ---------------------------------------------------------------------------
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (ar_accept) begin
      inc_vec[gnt_idx] = 1'b1;
    end
    if (pipe_take && pipe_last_q) begin
      dec_vec[pipe_sel] = 1'b1;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) begin
          underflow = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  assign err_d = err_q || underflow || (r_accept && !r_id_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_valid_q   <= 1'b0;
      last_grant_q <= LastIdx;
      pipe_valid_q <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      ar_valid_q   <= ar_valid_d;
      last_grant_q <= last_grant_d;
      pipe_valid_q <= pipe_valid_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign outstanding = cnt_q;
  assign err_bad_id  = err_q;

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter READ_MASTERS, default 2, number of read masters (1..16).
REQ-002 SHALL have parameter ARB_MODE, default ARB_FIXED, grant policy (ARB_FIXED or ARB_ROUND_ROBIN).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum bursts in flight per master (1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-006 SHALL have port axi_read_address, axi_read_address.master, -, external AR channel.
REQ-007 SHALL have port axi_read_data, axi_read_data.master, -, external R channel.
REQ-008 SHALL have port mem_read_address, axi_read_address.slave, [READ_MASTERS], per-master AR.
REQ-009 SHALL have port mem_read_data, axi_read_data.slave, [READ_MASTERS], per-master R.
REQ-010 SHALL have port outstanding, output, READ_MASTERS x 4, per-master in-flight burst count.
REQ-011 SHALL have port err_bad_id, output, 1, sticky flag for an unroutable R beat.

Function
REQ-012 SHALL require master i to drive ARID = i; the block forwards ARID/ARLEN/ARADDR unchanged.
REQ-013 SHALL treat master i as eligible when ARVALID[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-014 SHALL under ARB_FIXED grant the lowest-index eligible master.
REQ-015 SHALL under ARB_ROUND_ROBIN grant the first eligible master searching from last_grant+1 modulo READ_MASTERS.
REQ-016 SHALL update last_grant only on an accepted AR handshake.
REQ-017 SHALL register AR in one stage: stage_ready = !ARVALID_out || ARREADY; ARREADY[g] = stage_ready for the granted master only; all other ARREADY = 0.
REQ-018 SHALL hold the AR output payload stable while ARVALID_out=1 and ARREADY=0.
REQ-019 SHALL add exactly 1 cycle latency on AR; back-to-back grants SHALL sustain 1 beat/cycle when ARREADY stays high.
REQ-020 SHALL increment outstanding[i] when master i's AR is accepted into the stage.
REQ-021 SHALL decrement outstanding[i] when an RLAST beat is accepted by master i (RVALID[i] && RREADY[i]).
REQ-022 SHALL leave the count unchanged on a simultaneous increment and decrement for the same master.
REQ-023 SHALL register R in one stage: RREADY_ext = !pipe_valid || RREADY[pipe_id]; RVALID[i] = pipe_valid && pipe_id == i; the payload fans out to all masters.
REQ-024 SHALL add exactly 1 cycle latency on R and sustain 1 beat/cycle when the target master is ready.
REQ-025 SHALL accept an R beat with RID >= READ_MASTERS, drop it without presenting it, and set err_bad_id.
REQ-026 SHALL set err_bad_id on an RLAST beat for a master whose count is 0; that count SHALL stay at 0.
REQ-027 SHALL clear err_bad_id only by reset.
REQ-028 SHALL allow R data to return out of order across IDs; ordering is the responsibility of the memory.

Reset
REQ-029 SHALL on rst_n=0 immediately force ARVALID_out=0, all RVALID=0, pipe_valid=0, all outstanding=0 and err_bad_id=0.
REQ-030 SHALL reset last_grant to READ_MASTERS-1 so master 0 has first round-robin priority.
REQ-031 SHALL leave payload registers unreset; an in-flight burst lost to reset mid-operation is not recovered.

Structure
REQ-032 SHALL take arb_mode_t (ARB_FIXED=0, ARB_ROUND_ROBIN=1) from the shared mips_core package, alongside ADDR_WIDTH and DATA_WIDTH.
REQ-033 SHALL place the eligibility and rotation search in one sub-module, rr_grant_picker (request vector, base pointer -> grant index and grant valid), used in both modes with base 0 under ARB_FIXED.

Verification
REQ-034 SHALL verify: READ_MASTERS=2, ARB_FIXED, both ARVALID on the same cycle with ARREADY=1 -> ID0 on AR at cycle+1 and ID1 at cycle+2.
REQ-035 SHALL verify: READ_MASTERS=3, ARB_ROUND_ROBIN, all masters request continuously -> grant order 0,1,2,0,1,2.
REQ-036 SHALL verify: MAX_OUTSTANDING=2, master 0 issues 3 ARs with no R returned -> third ARREADY stays 0 until an RLAST for ID0 is accepted; outstanding[0] reads 2.
REQ-037 SHALL verify: R beat RID=1 while RREADY[1]=0 for 3 cycles -> RVALID[1] held with stable payload; RREADY_ext=0 for those 3 cycles.
REQ-038 SHALL verify: R beat RID=5 with READ_MASTERS=2 -> no RVALID asserted and err_bad_id=1 until reset.
REQ-039 SHALL verify: rst_n dropped mid-burst -> ARVALID_out, all RVALID and outstanding go to 0 without waiting for a clock edge.
